// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 32-bit to 16-bit SRAM sequencer.
// Optional round-robin arbitration: define SRAM_ARB_ROUND_ROBIN_EN.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    localparam int WORD_AW = SRAM_AW - 1;

    localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;

    // Byte address to 32-bit SRAM word index; out-of-range wraps.
    function automatic logic [WORD_AW-1:0] word_of(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        return WORD_AW'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_req_arbiter.sv
// Two-port request arbiter with held grant.
// Fixed priority to port 0 unless SRAM_ARB_ROUND_ROBIN_EN is defined.
module sram_req_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic pick,
    output logic grant
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last;

    // Starts at port 1 so the first contended request goes to port 0.
    always_comb begin
        pick = req1 & ~req0;
        if (req0 && req1)
            pick = ~last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= 1'b1;
        else if (take)
            last <= pick;
    end
`else
    always_comb pick = req1 & ~req0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            grant <= 1'b0;
        else if (take)
            grant <= pick;
    end

endmodule

// File: rtl/sram_arbiter_ctrl.sv
// Splits 32-bit accesses from two masters into low/high half-word SRAM phases.
// Optional round-robin arbitration: define SRAM_ARB_ROUND_ROBIN_EN.
module sram_arbiter_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic               req1,
    input  logic               we0,
    input  logic               we1,
    input  logic [31:0]        addr0,
    input  logic [31:0]        addr1,
    input  logic [31:0]        wdata0,
    input  logic [31:0]        wdata1,
    output logic               ready0,
    output logic               ready1,
    output logic [31:0]        rdata0,
    output logic [31:0]        rdata1,
    output logic               stall0,
    output logic               stall1,
    output logic [SRAM_AW-1:0] SRAMAddress,
    inout  wire  [SRAM_DW-1:0] SRAMData,
    output logic               SRAMWE,
    output logic               SRAMUB,
    output logic               SRAMLB,
    output logic               SRAMCE,
    output logic               SRAMOE
);

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

    state_t             state;
    state_t             state_nx;
    logic [2:0]         cnt;
    logic               phase_end;
    logic               active;
    logic               drive;
    logic               half;
    logic               take;
    logic               pick;
    logic               grant;
    logic [WORD_AW-1:0] word_r;
    logic               we_r;
    logic [31:0]        wdata_r;
    logic [SRAM_DW-1:0] rlo_r;

    assign phase_end = (cnt == WAIT_LAST);
    assign active    = (state == LO) || (state == HI);
    assign take      = (state == IDLE) && (req0 || req1);

    sram_req_arbiter u_arb (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .req1  (req1),
        .take  (take),
        .pick  (pick),
        .grant (grant)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (req0 || req1) state_nx = LO;
            LO:   if (phase_end) state_nx = HI;
            HI:   if (phase_end) state_nx = DONE;
            DONE: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= (active && !phase_end) ? cnt + 3'd1 : 3'd0;
        end
    end

    // Read halves land on the last cycle of each phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_r  <= '0;
            we_r    <= 1'b0;
            wdata_r <= '0;
            rlo_r   <= '0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            if (take) begin
                word_r  <= word_of(pick ? addr1 : addr0, BASE_ADDR);
                we_r    <= pick ? we1 : we0;
                wdata_r <= pick ? wdata1 : wdata0;
            end
            if (state == LO && phase_end && !we_r)
                rlo_r <= SRAMData;
            if (state == HI && phase_end && !we_r) begin
                if (grant)
                    rdata1 <= {SRAMData, rlo_r};
                else
                    rdata0 <= {SRAMData, rlo_r};
            end
        end
    end

    assign half  = (state == HI) ? HALF_HI : HALF_LO;
    assign drive = active && we_r;

    assign SRAMAddress = {word_r, half};
    assign SRAMWE      = ~drive;
    assign SRAMData    = drive ? (half ? wdata_r[31:16] : wdata_r[15:0])
                               : {SRAM_DW{1'bz}};

    assign SRAMUB = 1'b0;
    assign SRAMLB = 1'b0;
    assign SRAMCE = 1'b0;
    assign SRAMOE = 1'b0;

    assign ready0 = (state == DONE) && !grant;
    assign ready1 = (state == DONE) && grant;
    assign stall0 = req0 & ~ready0;
    assign stall1 = req1 & ~ready1;

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Bench for sram_arbiter_ctrl: two instances (1 and 0 wait states) on SRAM models.
// Completion order and read data are checked by a scoreboard queue.
module tb_sram_arbiter_ctrl;

    typedef struct {
        int          inst;
        int          port;
        logic        chk;
        logic [31:0] data;
    } sb_t;

    typedef struct {
        int          inst;
        int          port;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        logic        chk;
        logic        busz;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a;
    logic        rst_b;
    logic        req   [2][2];
    logic        we    [2][2];
    logic [31:0] addr  [2][2];
    logic [31:0] wdata [2][2];
    logic [31:0] rdata [2][2];
    logic        ready [2][2];
    logic        stall [2][2];
    logic [17:0] saddr [2];
    logic        swe   [2];
    logic        model_en [2];
    wire  [15:0] sd_a;
    wire  [15:0] sd_b;
    wire  [3:0]  tie_a;
    wire  [3:0]  tie_b;

    logic [15:0] mem_a [0:262143];
    logic [15:0] mem_b [0:262143];

    int  nchecks;
    int  nfail;
    sb_t sbq[$];

    sram_arbiter_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst_a),
        .req0(req[0][0]), .req1(req[0][1]),
        .we0(we[0][0]), .we1(we[0][1]),
        .addr0(addr[0][0]), .addr1(addr[0][1]),
        .wdata0(wdata[0][0]), .wdata1(wdata[0][1]),
        .ready0(ready[0][0]), .ready1(ready[0][1]),
        .rdata0(rdata[0][0]), .rdata1(rdata[0][1]),
        .stall0(stall[0][0]), .stall1(stall[0][1]),
        .SRAMAddress(saddr[0]), .SRAMData(sd_a), .SRAMWE(swe[0]),
        .SRAMUB(tie_a[3]), .SRAMLB(tie_a[2]),
        .SRAMCE(tie_a[1]), .SRAMOE(tie_a[0])
    );

    sram_arbiter_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst_b),
        .req0(req[1][0]), .req1(req[1][1]),
        .we0(we[1][0]), .we1(we[1][1]),
        .addr0(addr[1][0]), .addr1(addr[1][1]),
        .wdata0(wdata[1][0]), .wdata1(wdata[1][1]),
        .ready0(ready[1][0]), .ready1(ready[1][1]),
        .rdata0(rdata[1][0]), .rdata1(rdata[1][1]),
        .stall0(stall[1][0]), .stall1(stall[1][1]),
        .SRAMAddress(saddr[1]), .SRAMData(sd_b), .SRAMWE(swe[1]),
        .SRAMUB(tie_b[3]), .SRAMLB(tie_b[2]),
        .SRAMCE(tie_b[1]), .SRAMOE(tie_b[0])
    );

    assign sd_a = (model_en[0] && swe[0] && !tie_a[0]) ? mem_a[saddr[0]] : 16'hzzzz;
    assign sd_b = (model_en[1] && swe[1] && !tie_b[0]) ? mem_b[saddr[1]] : 16'hzzzz;

    always @(posedge clk) begin
        if (swe[0] === 1'b0) mem_a[saddr[0]] <= sd_a;
        if (swe[1] === 1'b0) mem_b[saddr[1]] <= sd_b;
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        sb_t e;
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++)
                if (ready[i][p] === 1'b1) begin
                    if (sbq.size() == 0) begin
                        nchecks++;
                        nfail++;
                        $display("FAIL sb_unexpected: got ready inst=%0d port=%0d expected none",
                                 i, p);
                    end else begin
                        e = sbq.pop_front();
                        check("sb_inst_port", i * 2 + p, e.inst * 2 + e.port);
                        if (e.chk) check("sb_rdata", rdata[i][p], e.data);
                    end
                end
    end

    function automatic logic bus_quiet(input int inst);
        logic [15:0] b;
        b = (inst == 0) ? sd_a : sd_b;
        return (b === 16'hzzzz) || (b === 16'h0000);
    endfunction

    task automatic access(input int inst, input int port, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input logic chk,
                          input logic busz);
        int   lat;
        int   welow;
        int   wc;
        logic seen;
        logic bad_bus;
        wc = (inst == 0) ? 1 : 0;
        sbq.push_back('{inst, port, chk, exp});
        model_en[inst] = ~busz;
        we[inst][port] = w;
        addr[inst][port] = a;
        wdata[inst][port] = d;
        req[inst][port] = 1'b1;
        lat = 0;
        welow = 0;
        seen = 1'b0;
        bad_bus = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (swe[inst] === 1'b0) welow++;
            if (busz && !bus_quiet(inst)) bad_bus = 1'b1;
            if (lat == 1) check("stall_busy", stall[inst][port], 1);
            if (ready[inst][port] === 1'b1) begin
                seen = 1'b1;
                check("stall_done", stall[inst][port], 0);
            end
        end
        check("latency", seen ? lat : 999, 2 * (wc + 1) + 1);
        check("we_low_cycles", welow, w ? 2 * (wc + 1) : 0);
        if (busz) check("read_bus_undriven", bad_bus, 0);
        req[inst][port] = 1'b0;
        model_en[inst] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset_a();
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        rst_a = 1'b0;
    endtask

    vec_t vt[9];
    int   n;
    int   t;
    int   r0;
    int   r1;

    initial begin
        nchecks = 0;
        nfail = 0;
        vt[0] = '{0, 0, 1'b1, 32'd1024,   32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        vt[1] = '{0, 0, 1'b0, 32'd1024,   32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
        vt[2] = '{0, 0, 1'b0, 32'd1027,   32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
        vt[3] = '{0, 0, 1'b0, 32'd525312, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
        vt[4] = '{0, 1, 1'b1, 32'd1040,   32'hCAFEF00D, 32'h0,        1'b0, 1'b0};
        vt[5] = '{0, 1, 1'b0, 32'd1040,   32'h0,        32'hCAFEF00D, 1'b1, 1'b0};
        vt[6] = '{0, 1, 1'b0, 32'd1040,   32'h5A5AA5A5, 32'h0,        1'b0, 1'b1};
        vt[7] = '{1, 0, 1'b1, 32'd1036,   32'hA5A55A5A, 32'h0,        1'b0, 1'b0};
        vt[8] = '{1, 0, 1'b0, 32'd1036,   32'h0,        32'hA5A55A5A, 1'b1, 1'b0};

        rst_a = 1'b1;
        rst_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            model_en[i] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                req[i][p] = 1'b0;
                we[i][p] = 1'b0;
                addr[i][p] = 32'h0;
                wdata[i][p] = 32'h0;
            end
        end
        #12;
        check("rst_we", swe[0], 1);
        check("rst_addr", saddr[0], 0);
        check("rst_ready", {ready[0][0], ready[0][1]}, 0);
        check("rst_rdata0", rdata[0][0], 0);
        check("rst_rdata1", rdata[0][1], 0);
        check("rst_tied", tie_a, 0);
        check("rst_bus", bus_quiet(0), 1);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        model_en[0] = 1'b1;
        model_en[1] = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 9; v++)
            access(vt[v].inst, vt[v].port, vt[v].w, vt[v].a, vt[v].d,
                   vt[v].exp, vt[v].chk, vt[v].busz);

        check("mem_lo", mem_a[0], 16'hBEEF);
        check("mem_hi", mem_a[1], 16'hDEAD);
        check("rdata0_held", rdata[0][0], 32'hDEADBEEF);

        // Reset during the high phase of a write
        we[0][0] = 1'b1;
        addr[0][0] = 32'd1024;
        wdata[0][0] = 32'h12345678;
        req[0][0] = 1'b1;
        n = 0;
        while (saddr[0][0] !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rst_reach_hi", saddr[0][0], 1);
        model_en[0] = 1'b0;
        rst_a = 1'b1;
        #1;
        check("midrst_we", swe[0], 1);
        check("midrst_bus", bus_quiet(0), 1);
        check("midrst_ready", ready[0][0], 0);
        req[0][0] = 1'b0;
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        model_en[0] = 1'b1;
        check("midrst_mem_hi", mem_a[1], 16'hDEAD);
        check("midrst_mem_lo", mem_a[0], 16'h5678);
        access(0, 0, 1'b0, 32'd1024, 32'h0, 32'hDEAD5678, 1'b1, 1'b0);

        // Simultaneous requests
        pulse_reset_a();
        sbq.push_back('{0, 0, 1'b0, 32'h0});
        sbq.push_back('{0, 1, 1'b0, 32'h0});
        we[0][0] = 1'b1;
        we[0][1] = 1'b1;
        addr[0][0] = 32'd1028;
        addr[0][1] = 32'd1032;
        wdata[0][0] = 32'h1111AAAA;
        wdata[0][1] = 32'h2222BBBB;
        req[0][0] = 1'b1;
        req[0][1] = 1'b1;
        t = 0;
        r0 = 0;
        r1 = 0;
        while ((r0 == 0 || r1 == 0) && t < 40) begin
            @(posedge clk);
            #1;
            t++;
            if (ready[0][0] === 1'b1 && r0 == 0) begin
                r0 = t;
                req[0][0] = 1'b0;
            end
            if (ready[0][1] === 1'b1 && r1 == 0) begin
                r1 = t;
                req[0][1] = 1'b0;
            end
        end
        check("contend_ready0_at", r0, 5);
        check("contend_ready1_at", r1, 11);
        @(posedge clk);
        #1;
        check("contend_mem0", {mem_a[3], mem_a[2]}, 32'h1111AAAA);
        check("contend_mem1", {mem_a[5], mem_a[4]}, 32'h2222BBBB);

        // Both ports held continuously
        pulse_reset_a();
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 4; k++) sbq.push_back('{0, k % 2, 1'b0, 32'h0});
`else
        for (int k = 0; k < 4; k++) sbq.push_back('{0, 0, 1'b0, 32'h0});
`endif
        we[0][0] = 1'b0;
        we[0][1] = 1'b0;
        addr[0][0] = 32'd1024;
        addr[0][1] = 32'd1024;
        req[0][0] = 1'b1;
        req[0][1] = 1'b1;
        n = 0;
        t = 0;
        while (n < 4 && t < 80) begin
            @(posedge clk);
            #1;
            t++;
            if (ready[0][0] === 1'b1 || ready[0][1] === 1'b1) n++;
        end
        req[0][0] = 1'b0;
        req[0][1] = 1'b0;
        check("held_grants", n, 4);
        repeat (3) @(posedge clk);
        #1;

        check("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
